spi_peripheral: RTL

- SPI target (peripheral) endpoint; the far end of the team's SPI controller.
- Receives SCLK, COPI and CS_n from an external controller; shifts data MSB-first over CIPO.
- Exchanges bytes with local logic through a valid/ready TX holding register and a one-cycle RX valid pulse.
- All SPI pins are asynchronous to i_clk: they are synchronized and edge-detected internally, so i_clk must run at ≥4× SCLK.

---
 rtl/spi_peripheral_pkg.sv | 27 ++
 rtl/spi_peripheral_if.sv | 26 ++
 rtl/spi_peripheral_sync.sv | 49 ++++
 rtl/spi_peripheral.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/spi_peripheral_pkg.sv
// Shared SPI definitions: FSM state encoding, default widths and the
// CPOL/CPHA mode constants used by both the peripheral and the controller.
package spi_peripheral_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } spi_state_e;

   localparam int DEFAULT_DATA_WIDTH  = 8;
   localparam int DEFAULT_SYNC_STAGES = 2;

   // Mode constants are packed as {cpol, cpha}
   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

   function automatic logic mode_cpol(input logic [1:0] mode);
      return mode[1];
   endfunction

   function automatic logic mode_cpha(input logic [1:0] mode);
      return mode[0];
   endfunction

endpackage

// File: rtl/spi_peripheral_if.sv
// Local-side word interface of the SPI peripheral: TX holding register
// handshake plus the received-word strobe.
interface spi_peripheral_if
   import spi_peripheral_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
   logic [DATA_WIDTH-1:0] tx;
   logic                  tx_valid;
   logic                  tx_ready;
   logic                  tx_underrun;
   logic [DATA_WIDTH-1:0] rx;
   logic                  rx_valid;

   // Local logic that feeds and drains the peripheral
   modport master (
      output tx, tx_valid,
      input  tx_ready, tx_underrun, rx, rx_valid
   );

   // The peripheral itself
   modport slave (
      input  tx, tx_valid,
      output tx_ready, tx_underrun, rx, rx_valid
   );
endinterface

// File: rtl/spi_peripheral_sync.sv
// Input synchronizer for one asynchronous SPI pin: a STAGES-deep flop chain
// with a programmable reset value, followed by one history flop so the
// parent can detect edges on the synchronized signal.
module spi_peripheral_sync
   import spi_peripheral_pkg::*;
#(
   parameter int   STAGES    = DEFAULT_SYNC_STAGES,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic d,
   output logic q,
   output logic q_prev
);

   logic prev_reg;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         logic stage_reg;
         if (gi == 0) begin : g_first
            // First stage samples the raw asynchronous pin
            always_ff @(posedge i_clk) begin
               if (!i_rst_n) stage_reg <= RESET_VAL;
               else          stage_reg <= d;
            end
         end else begin : g_next
            // Later stages resolve metastability of the previous one
            always_ff @(posedge i_clk) begin
               if (!i_rst_n) stage_reg <= RESET_VAL;
               else          stage_reg <= g_stage[gi-1].stage_reg;
            end
         end
      end
   endgenerate

   assign q = g_stage[STAGES-1].stage_reg;

   // History flop: q != q_prev marks an edge of the synchronized pin
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) prev_reg <= RESET_VAL;
      else          prev_reg <= q;
   end

   assign q_prev = prev_reg;

endmodule

// File: rtl/spi_peripheral.sv
// SPI target endpoint. SCLK/COPI/CS_n are oversampled by i_clk (>= 4x SCLK),
// edge-detected, and used to shift words MSB-first in both directions.
// Local logic writes the TX holding register via valid/ready and receives
// each complete word with a one-cycle rx_valid strobe.
module spi_peripheral
   import spi_peripheral_pkg::*;
#(
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_cpol,
   input  logic                 i_cpha,
   spi_peripheral_if.slave      bus,
   input  logic                 i_sclk,
   input  logic                 i_copi,
   input  logic                 i_cs_n,
   output logic                 o_cipo,
   output logic                 o_cipo_en,
   output logic                 o_busy
);

   localparam int              CNT_W    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   // Synchronized pins and their one-cycle-old copies
   logic s_sclk, sclk_prev;
   logic s_copi, copi_hist_unused;
   logic s_cs_n, cs_prev;

   spi_peripheral_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .d(i_sclk), .q(s_sclk), .q_prev(sclk_prev)
   );

   // COPI is only ever sampled, never edge-detected, so its history is left idle
   spi_peripheral_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .d(i_copi), .q(s_copi), .q_prev(copi_hist_unused)
   );

   // CS_n clears to 1 so that reset never looks like a select
   spi_peripheral_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .d(i_cs_n), .q(s_cs_n), .q_prev(cs_prev)
   );

   spi_state_e              state_reg;
   logic                    busy_reg;
   logic                    cpol_reg;
   logic                    cpha_reg;
   logic                    first_word_reg;
   logic [CNT_W-1:0]        bit_cnt_reg;
   logic [DATA_WIDTH-1:0]   shift_reg;
   logic [DATA_WIDTH-2:0]   rx_shift_reg;
   logic [DATA_WIDTH-1:0]   rx_reg;
   logic                    rx_valid_reg;
   logic [DATA_WIDTH-1:0]   hold_reg;
   logic                    tx_ready_reg;
   logic                    underrun_reg;

   logic                    sclk_edge, lead_edge, trail_edge;
   logic                    sample_edge, shift_edge;
   logic                    cs_fall, cs_rise;
   logic                    word_done;
   logic                    load_req;
   logic [DATA_WIDTH-1:0]   rx_word;

   // Leading edge leaves the latched idle level, trailing edge returns to it
   assign sclk_edge   = s_sclk ^ sclk_prev;
   assign lead_edge   = sclk_edge & (s_sclk != cpol_reg);
   assign trail_edge  = sclk_edge & (s_sclk == cpol_reg);
   assign sample_edge = cpha_reg ? trail_edge : lead_edge;
   assign shift_edge  = cpha_reg ? lead_edge  : trail_edge;

   assign cs_fall     = cs_prev & ~s_cs_n;
   assign cs_rise     = ~cs_prev & s_cs_n;

   assign word_done   = sample_edge & (bit_cnt_reg == LAST_BIT);
   assign rx_word     = {rx_shift_reg, s_copi};

   // Shifter loads: frame start; CPHA=0 reloads as soon as a word completes;
   // CPHA=1 reloads on the first leading edge of every word after the first
   // (the first word was already loaded at frame start).
   assign load_req = (state_reg == ST_IDLE)
                   ? cs_fall
                   : (!cs_rise &&
                      ((word_done && !cpha_reg) ||
                       (shift_edge && cpha_reg && (bit_cnt_reg == '0) && !first_word_reg)));

   // Frame FSM with shifter, receiver and TX holding register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_reg      <= ST_IDLE;
         busy_reg       <= 1'b0;
         cpol_reg       <= 1'b0;
         cpha_reg       <= 1'b0;
         first_word_reg <= 1'b0;
         bit_cnt_reg    <= '0;
         shift_reg      <= '0;
         rx_shift_reg   <= '0;
         rx_reg         <= '0;
         rx_valid_reg   <= 1'b0;
         hold_reg       <= '0;
         tx_ready_reg   <= 1'b1;
         underrun_reg   <= 1'b0;
      end else begin
         rx_valid_reg <= 1'b0;
         underrun_reg <= 1'b0;

         if (bus.tx_valid && tx_ready_reg) begin
            hold_reg     <= bus.tx;
            tx_ready_reg <= 1'b0;
         end

         case (state_reg)
            ST_IDLE: begin
               if (cs_fall) begin
                  state_reg      <= ST_ACTIVE;
                  busy_reg       <= 1'b1;
                  cpol_reg       <= i_cpol;
                  cpha_reg       <= i_cpha;
                  bit_cnt_reg    <= '0;
                  first_word_reg <= 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (cs_rise) begin
                  // Partial word is dropped; holding register is left alone
                  state_reg    <= ST_IDLE;
                  busy_reg     <= 1'b0;
                  bit_cnt_reg  <= '0;
                  shift_reg    <= '0;
                  rx_shift_reg <= '0;
               end else begin
                  if (sample_edge) begin
                     rx_shift_reg <= rx_word[DATA_WIDTH-2:0];
                     if (word_done) begin
                        rx_reg         <= rx_word;
                        rx_valid_reg   <= 1'b1;
                        bit_cnt_reg    <= '0;
                        first_word_reg <= 1'b0;
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                     end
                  end
                  // A count of zero marks a word boundary, which loads instead of shifting
                  if (shift_edge && (bit_cnt_reg != '0)) begin
                     shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                  end
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
            end
         endcase

         if (load_req) begin
            if (tx_ready_reg) begin
               shift_reg    <= '0;
               underrun_reg <= 1'b1;
            end else begin
               shift_reg    <= hold_reg;
               tx_ready_reg <= 1'b1;
            end
         end
      end
   end

   assign o_cipo          = shift_reg[DATA_WIDTH-1];
   assign o_cipo_en       = busy_reg;
   assign o_busy          = busy_reg;
   assign bus.tx_ready    = tx_ready_reg;
   assign bus.tx_underrun = underrun_reg;
   assign bus.rx          = rx_reg;
   assign bus.rx_valid    = rx_valid_reg;

endmodule
